// File: rtl/fetch_pc_gen.sv
// Fetch-side PC sequencer.
//
// Generates the instruction-fetch address with a valid/ready handshake toward
// instruction memory. It consumes the registered branch redirect from the
// branch-resolution stage. A taken redirect squashes wrong-path fetches with a
// counted flush window, then fetching resumes at the target. A misaligned
// redirect target parks the block in a sticky error state until reset.
//
// Ports:
//   clk           system clock, all logic on rising edge
//   rsta          synchronous active-high reset
//   branch_in     registered redirect request
//   jump_pc_in    registered redirect target, qualified by branch_in
//   stall         hazard-unit stall, blocks fetch acceptance
//   imem_ready    instruction memory accepts a request this cycle
//   pc            current fetch address
//   pc_valid      fetch request valid
//   flush         squash IF/ID contents
//   redirect_ack  one-cycle pulse per taken redirect
//   misaligned    sticky error, redirect target not word-aligned
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rsta,
    input  logic        branch_in,
    input  logic [31:0] jump_pc_in,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        redirect_ack,
    output logic        misaligned
);

    typedef enum logic [1:0] {StBoot, StRun, StFlush, StErr} state_e;

    // The counter holds the number of flush cycles left after the current one.
    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);
    localparam logic [31:0] Step     = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        ack_q, ack_d;
    logic        mis_q, mis_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;

    assign accept = pc_valid_q & imem_ready & ~stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = flush_q;
        ack_d      = 1'b0;
        mis_d      = mis_q;
        cnt_d      = cnt_q;

        case (state_q)
            StBoot: begin
                state_d    = StRun;
                pc_d       = RESET_PC;
                pc_valid_d = 1'b1;
            end
            StRun, StFlush: begin
                if (branch_in) begin
                    // Redirect wins over stall and over a same-cycle accept.
                    pc_d       = jump_pc_in;
                    pc_valid_d = 1'b0;
                    flush_d    = 1'b1;
                    if (jump_pc_in[1:0] != 2'b00) begin
                        state_d = StErr;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = StFlush;
                        ack_d   = 1'b1;
                        cnt_d   = FlushInit;
                    end
                end else if (state_q == StFlush) begin
                    // Flush window runs regardless of stall and imem_ready.
                    if (cnt_q == 4'd0) begin
                        state_d    = StRun;
                        flush_d    = 1'b0;
                        pc_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (accept) begin
                    pc_d = pc_q + Step;
                end
            end
            StErr: begin
                // Frozen until reset; ack was already low on entry.
                state_d = StErr;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rsta) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            ack_q      <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            ack_q      <= ack_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign flush        = flush_q;
    assign redirect_ack = ack_q;
    assign misaligned   = mis_q;

endmodule
